// File: rtl/antitheft_pkg.sv
// Shared definitions for the vehicle anti-theft controller: FSM state codes,
// parameter-bank selectors and the power-on values of the time bank.
package antitheft_pkg;

    typedef enum logic [2:0] {
        ST_ARMED     = 3'd0,
        ST_TRIGGERED = 3'd1,
        ST_ALARM     = 3'd2,
        ST_DISARMED  = 3'd3,
        ST_IGN_OFF   = 3'd4,
        ST_DOOR_OPEN = 3'd5,
        ST_ARM_DELAY = 3'd6,
        ST_LOCKOUT   = 3'd7
    } state_e;

    localparam logic [1:0] SEL_T_ARM = 2'd0;
    localparam logic [1:0] SEL_T_DRV = 2'd1;
    localparam logic [1:0] SEL_T_PAS = 2'd2;
    localparam logic [1:0] SEL_T_ALM = 2'd3;

    localparam int DEF_T_ARM = 6;
    localparam int DEF_T_DRV = 8;
    localparam int DEF_T_PAS = 15;
    localparam int DEF_T_ALM = 10;

    // Divider width; a 1 Hz clock still needs a 1-bit counter.
    function automatic int div_width(input int hz);
        if (hz > 1) begin
            return $clog2(hz);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/antitheft_timer.sv
// One-second tick divider plus TW-bit seconds down-counter. A load restarts
// the second boundary so every loaded interval is whole seconds long.
module antitheft_timer
    import antitheft_pkg::*;
#(
    parameter int TW     = 4,
    parameter int CLK_HZ = 100_000_000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tick,
    output logic          expired,
    output logic [TW-1:0] count
);

    localparam int DW = div_width(CLK_HZ);

    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick_s;

    assign tick_s  = (div_q == DW'(CLK_HZ - 1));
    assign tick    = tick_s;
    // A zero count reports expiry on the next tick instead of wrapping.
    assign expired = tick_s && (cnt_q == '0);
    assign count   = cnt_q;

    // Next-state logic for divider and down-counter.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            div_d = '0;
            cnt_d = load_val;
        end else if (tick_s) begin
            div_d = '0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - TW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Divider and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/antitheft_ctrl_n.sv
// Anti-theft controller: arming FSM, reprogrammable time bank, retrigger
// counting with lockout. Every output is a flop updated one cycle after input.
module antitheft_ctrl_n
    import antitheft_pkg::*;
#(
    parameter int NUM_DOORS  = 2,
    parameter int TW         = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int MAX_RETRIG = 3,
    parameter int T_ARM_RST  = DEF_T_ARM,
    parameter int T_DRV_RST  = DEF_T_DRV,
    parameter int T_PAS_RST  = DEF_T_PAS,
    parameter int T_ALM_RST  = DEF_T_ALM
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ignition,
    input  logic [NUM_DOORS-1:0] door,
    input  logic                 reprogram,
    input  logic [1:0]           param_sel,
    input  logic [TW-1:0]        param_value,
    output logic                 status,
    output logic                 siren_en,
    output logic [2:0]           state,
    output logic [TW-1:0]        count,
    output logic                 lockout
);

    localparam int RW = 3;

    state_e        state_q, state_d;
    logic [RW-1:0] retrig_q, retrig_d;
    logic [TW-1:0] bank_q [4];
    logic [TW-1:0] bank_d [4];
    logic          status_q, status_d;
    logic          siren_q, siren_d;
    logic          lockout_q, lockout_d;

    logic          load_s;
    logic [TW-1:0] load_val_s;
    logic          tick_s;
    logic          expired_s;
    logic          any_door_s;
    logic [RW-1:0] retrig_inc_s;

    assign any_door_s   = |door;
    assign retrig_inc_s = retrig_q + RW'(1);

    antitheft_timer #(
        .TW     (TW),
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .tick     (tick_s),
        .expired  (expired_s),
        .count    (count)
    );

    // Transition logic; reprogram beats ignition beats doors beats expiry.
    always_comb begin
        state_d    = state_q;
        retrig_d   = retrig_q;
        bank_d     = bank_q;
        load_s     = 1'b0;
        load_val_s = '0;
        if (reprogram) begin
            bank_d[param_sel] = param_value;
            state_d           = ST_ARMED;
            load_s            = 1'b1;
            load_val_s        = '0;
        end else if (ignition && (state_q != ST_DISARMED)) begin
            state_d  = ST_DISARMED;
            retrig_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (any_door_s) begin
                        state_d    = ST_TRIGGERED;
                        load_s     = 1'b1;
                        load_val_s = door[0] ? bank_q[SEL_T_DRV] : bank_q[SEL_T_PAS];
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_TRIGGERED: begin
                    if (expired_s) begin
                        state_d    = ST_ALARM;
                        load_s     = 1'b1;
                        load_val_s = bank_q[SEL_T_ALM];
                    end else begin
                        state_d = ST_TRIGGERED;
                    end
                end
                ST_ALARM: begin
                    // An open door keeps the siren period from ever running down.
                    if (any_door_s) begin
                        load_s     = 1'b1;
                        load_val_s = bank_q[SEL_T_ALM];
                    end else if (expired_s) begin
                        retrig_d = retrig_inc_s;
                        state_d  = (retrig_inc_s == RW'(MAX_RETRIG)) ? ST_LOCKOUT : ST_ARMED;
                    end else begin
                        state_d = ST_ALARM;
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) begin
                        state_d = ST_IGN_OFF;
                    end else begin
                        state_d = ST_DISARMED;
                    end
                end
                ST_IGN_OFF: begin
                    if (door[0]) begin
                        state_d = ST_DOOR_OPEN;
                    end else begin
                        state_d = ST_IGN_OFF;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (!door[0]) begin
                        state_d    = ST_ARM_DELAY;
                        load_s     = 1'b1;
                        load_val_s = bank_q[SEL_T_ARM];
                    end else begin
                        state_d = ST_DOOR_OPEN;
                    end
                end
                ST_ARM_DELAY: begin
                    if (any_door_s) begin
                        state_d = ST_DOOR_OPEN;
                    end else if (expired_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_ARM_DELAY;
                    end
                end
                ST_LOCKOUT: begin
                    state_d = ST_LOCKOUT;
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so outputs and state flop together.
    always_comb begin
        siren_d   = (state_d == ST_ALARM);
        lockout_d = (state_d == ST_LOCKOUT);
        case (state_d)
            ST_ARMED: begin
                // Blink phase restarts at 0 whenever ARMED is freshly entered.
                if ((state_q == ST_ARMED) && !reprogram) begin
                    status_d = status_q ^ tick_s;
                end else begin
                    status_d = 1'b0;
                end
            end
            ST_TRIGGERED, ST_ALARM, ST_LOCKOUT: status_d = 1'b1;
            default:                            status_d = 1'b0;
        endcase
    end

    // State, retrigger count, time bank and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= ST_ARMED;
            retrig_q          <= '0;
            bank_q[SEL_T_ARM] <= TW'(T_ARM_RST);
            bank_q[SEL_T_DRV] <= TW'(T_DRV_RST);
            bank_q[SEL_T_PAS] <= TW'(T_PAS_RST);
            bank_q[SEL_T_ALM] <= TW'(T_ALM_RST);
            status_q          <= 1'b0;
            siren_q           <= 1'b0;
            lockout_q         <= 1'b0;
        end else begin
            state_q   <= state_d;
            retrig_q  <= retrig_d;
            bank_q    <= bank_d;
            status_q  <= status_d;
            siren_q   <= siren_d;
            lockout_q <= lockout_d;
        end
    end

    assign state    = state_q;
    assign status   = status_q;
    assign siren_en = siren_q;
    assign lockout  = lockout_q;

endmodule

// File: tb/tb_antitheft_ctrl_n.sv
// Directed bench for antitheft_ctrl_n at CLK_HZ=10 (one tick every 10 clocks).
module tb_antitheft_ctrl_n;
    import antitheft_pkg::*;

    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          ignition;
    logic [1:0]    door;
    logic          reprogram;
    logic [1:0]    param_sel;
    logic [TW-1:0] param_value;
    logic          status;
    logic          siren_en;
    logic [2:0]    state;
    logic [TW-1:0] count;
    logic          lockout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clock = ~clock;

    antitheft_ctrl_n #(
        .NUM_DOORS  (2),
        .TW         (TW),
        .CLK_HZ     (10),
        .MAX_RETRIG (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ignition    (ignition),
        .door        (door),
        .reprogram   (reprogram),
        .param_sel   (param_sel),
        .param_value (param_value),
        .status      (status),
        .siren_en    (siren_en),
        .state       (state),
        .count       (count),
        .lockout     (lockout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output int waited);
        waited = 0;
        while ((state !== target) && (waited < budget)) begin
            @(negedge clock);
            waited++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ignition = 1'b0; door = 2'b00; reprogram = 1'b0;
        param_sel = 2'd0; param_value = 4'd0;
        step(2);
        reset = 1'b0;
        check_eq("rst_state",   32'(state),    32'd0);
        check_eq("rst_count",   32'(count),    32'd0);
        check_eq("rst_status",  32'(status),   32'd0);
        check_eq("rst_siren",   32'(siren_en), 32'd0);
        check_eq("rst_lockout", 32'(lockout),  32'd0);

        // ARMED blink: status flips once per 10-clock tick
        cyc = 0;
        while ((status !== 1'b1) && (cyc < 15)) begin step(1); cyc++; end
        check_eq("blink_on", 32'(status), 32'd1);
        step(9);
        check_eq("blink_hold", 32'(status), 32'd1);
        step(1);
        check_eq("blink_off", 32'(status), 32'd0);

        // Driver door -> TRIGGERED with T_DRV=8; expiry on 9th tick
        door = 2'b01; step(1);
        check_eq("trig_state",  32'(state),  32'd1);
        check_eq("trig_count",  32'(count),  32'd8);
        check_eq("trig_status", 32'(status), 32'd1);
        door = 2'b00;
        step(80);
        check_eq("trig_cnt0_state", 32'(state), 32'd1);
        check_eq("trig_cnt0",       32'(count), 32'd0);
        step(10);
        check_eq("alarm_state", 32'(state),    32'd2);
        check_eq("alarm_siren", 32'(siren_en), 32'd1);
        check_eq("alarm_count", 32'(count),    32'd10);

        // Door held open in ALARM: reloaded every cycle, no countdown
        door = 2'b01; step(500);
        check_eq("hold_count", 32'(count), 32'd10);
        check_eq("hold_state", 32'(state), 32'd2);
        door = 2'b00; step(100);
        check_eq("close_cnt0",  32'(count), 32'd0);
        check_eq("close_state", 32'(state), 32'd2);
        step(10);
        check_eq("rearm_state",  32'(state),          32'd0);
        check_eq("rearm_siren",  32'(siren_en),       32'd0);
        check_eq("rearm_retrig", 32'(dut.retrig_q),   32'd1);

        // Passenger door -> T_PAS=15; second alarm cycle
        door = 2'b10; step(1);
        check_eq("pas_count", 32'(count), 32'd15);
        check_eq("pas_state", 32'(state), 32'd1);
        door = 2'b00;
        wait_state(3'(ST_ALARM), 400, cyc);
        check_eq("pas_alarm_state", 32'(state), 32'd2);
        check_eq("pas_alarm_cyc",   32'(cyc),   32'd160);
        wait_state(3'(ST_ARMED), 400, cyc);
        check_eq("pas_rearm_cyc",    32'(cyc),          32'd110);
        check_eq("pas_rearm_retrig", 32'(dut.retrig_q), 32'd2);

        // Both doors: driver time wins; third cycle -> LOCKOUT
        door = 2'b11; step(1);
        check_eq("both_count", 32'(count), 32'd8);
        door = 2'b00;
        wait_state(3'(ST_ALARM), 400, cyc);
        check_eq("both_alarm_cyc", 32'(cyc), 32'd90);
        wait_state(3'(ST_LOCKOUT), 400, cyc);
        check_eq("lock_cyc",     32'(cyc),      32'd110);
        check_eq("lock_state",   32'(state),    32'd7);
        check_eq("lock_flag",    32'(lockout),  32'd1);
        check_eq("lock_siren",   32'(siren_en), 32'd0);
        check_eq("lock_status",  32'(status),   32'd1);
        door = 2'b01; step(30);
        check_eq("lock_stay",        32'(state),  32'd7);
        check_eq("lock_status_hold", 32'(status), 32'd1);
        door = 2'b00;

        // Ignition leaves LOCKOUT and clears retrig
        ignition = 1'b1; step(1);
        check_eq("dis_state",   32'(state),        32'd3);
        check_eq("dis_retrig",  32'(dut.retrig_q), 32'd0);
        check_eq("dis_lockout", 32'(lockout),      32'd0);
        check_eq("dis_status",  32'(status),       32'd0);

        // Leave vehicle: IGN_OFF -> DOOR_OPEN -> ARM_DELAY, interrupted, redone
        ignition = 1'b0; step(1);
        check_eq("ignoff_state", 32'(state), 32'd4);
        door = 2'b01; step(1);
        check_eq("dopen_state", 32'(state), 32'd5);
        door = 2'b00; step(1);
        check_eq("adly_state", 32'(state), 32'd6);
        check_eq("adly_count", 32'(count), 32'd6);
        step(30);
        check_eq("adly_cnt3", 32'(count), 32'd3);
        door = 2'b10; step(1);
        check_eq("adly_abort", 32'(state), 32'd5);
        door = 2'b00; step(1);
        check_eq("adly2_state", 32'(state), 32'd6);
        check_eq("adly2_count", 32'(count), 32'd6);
        wait_state(3'(ST_ARMED), 200, cyc);
        check_eq("adly2_armed_cyc", 32'(cyc),   32'd70);
        check_eq("adly2_armed",     32'(state), 32'd0);

        // Reprogram T_DRV during TRIGGERED
        door = 2'b01; step(1);
        check_eq("rp_trig", 32'(state), 32'd1);
        door = 2'b00; reprogram = 1'b1; param_sel = 2'd1; param_value = 4'd3; step(1);
        check_eq("rp_state", 32'(state), 32'd0);
        check_eq("rp_count", 32'(count), 32'd0);
        reprogram = 1'b0; door = 2'b01; step(1);
        check_eq("rp_newdrv", 32'(count), 32'd3);
        door = 2'b00;

        // Reprogram and ignition together: reprogram wins
        reprogram = 1'b1; ignition = 1'b1; param_sel = 2'd2; param_value = 4'd4; step(1);
        check_eq("prio_state", 32'(state), 32'd0);
        reprogram = 1'b0; ignition = 1'b0; door = 2'b10; step(1);
        check_eq("prio_newpas", 32'(count), 32'd4);
        door = 2'b00;

        // Asynchronous reset mid-countdown restores the bank
        step(15);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_state", 32'(state),  32'd0);
        check_eq("arst_count", 32'(count),  32'd0);
        check_eq("arst_status", 32'(status), 32'd0);
        @(negedge clock);
        reset = 1'b0; door = 2'b10; step(1);
        check_eq("arst_bank_pas", 32'(count), 32'd15);
        door = 2'b01; reprogram = 1'b0; step(1);
        door = 2'b00;
        ignition = 1'b1; step(1);
        ignition = 1'b0; step(1);
        check_eq("arst_ignoff", 32'(state), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
